// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I register fields and a decoder-style 32-bit immediate
// into an instruction word. The immediate format is chosen by imm_src. Encoded
// words stream to an instruction-memory writer along with a byte address.
// The pipeline is a single registered stage with valid/ready on both sides.
// Immediates that the format cannot represent, and illegal formats, are
// replaced by a NOP. They are flagged on out_err and counted in a saturating
// counter.
module instr_encoder #(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter int unsigned         ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_src,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [ERR_W-1:0]  err_count
);

    // Immediate formats, matching the core decoder's imm_src encoding.
    // Codes 3'b101 and 3'b110 are deliberately absent; they are illegal.
    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100,
        FMT_R = 3'b111
    } fmt_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        accept;
    logic        complete;

    // Range checks: the dropped upper bits must be pure sign extension.
    logic        sext_from_11;
    logic        sext_from_12;
    logic        sext_from_20;
    logic        low12_zero;
    logic        is_even;

    // Per-format packed words, before the legality substitution.
    logic [31:0] word_r;
    logic [31:0] word_i;
    logic [31:0] word_s;
    logic [31:0] word_b;
    logic [31:0] word_u;
    logic [31:0] word_j;

    logic [31:0] enc_instr;
    logic        enc_legal;

    // Accepting is allowed when the output stage is empty or is draining this cycle.
    assign in_ready = rst_n & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign complete = out_valid & out_ready;

    // Representability tests on the immediate.
    always_comb begin
        sext_from_11 = (&imm[31:11]) | ~(|imm[31:11]);
        sext_from_12 = (&imm[31:12]) | ~(|imm[31:12]);
        sext_from_20 = (&imm[31:20]) | ~(|imm[31:20]);
        low12_zero   = ~(|imm[11:0]);
        is_even      = ~imm[0];
    end

    // Bit placement for every format, each the exact inverse of the decoder's scatter.
    always_comb begin
        word_r = {funct7, rs2, rs1, funct3, rd, opcode};
        word_i = {imm[11:0], rs1, funct3, rd, opcode};
        word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        word_b = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        word_u = {imm[31:12], rd, opcode};
        word_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
    end

    // Select the word for the requested format and substitute a NOP when it is not legal.
    always_comb begin
        enc_instr = NOP_INSTR;
        enc_legal = 1'b0;
        case (imm_src)
            FMT_I: begin
                enc_legal = sext_from_11;
                enc_instr = word_i;
            end
            FMT_S: begin
                enc_legal = sext_from_11;
                enc_instr = word_s;
            end
            FMT_B: begin
                enc_legal = sext_from_12 & is_even;
                enc_instr = word_b;
            end
            FMT_J: begin
                enc_legal = sext_from_20 & is_even;
                enc_instr = word_j;
            end
            FMT_U: begin
                enc_legal = low12_zero;
                enc_instr = word_u;
            end
            FMT_R: begin
                enc_legal = 1'b1;
                enc_instr = word_r;
            end
            default: begin
                enc_legal = 1'b0;
                enc_instr = NOP_INSTR;
            end
        endcase
        if (!enc_legal) begin
            enc_instr = NOP_INSTR;
        end
    end

    // Output stage. The address advances only when a beat completes. The error
    // counter advances when an illegal request is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
            err_count <= '0;
        end else begin
            if (complete) begin
                out_addr <= out_addr + ADDR_W'(4);
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= enc_instr;
                out_err   <= ~enc_legal;
                if (!enc_legal && (err_count != '1)) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end else if (complete) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. Two instances share the same stimulus.
// The main instance uses default parameters. The second instance uses a narrow,
// non-zero-based address and a 2-bit error counter, which exercises address
// wrap and counter saturation. Expected values come from a behavioural model
// that builds each instruction arithmetically from the format rules. It also
// tracks the handshake at transaction level.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  imm_src = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_ready = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    logic        a_in_ready;
    logic        a_out_valid;
    logic [31:0] a_out_instr;
    logic [5:0]  a_out_addr;
    logic        a_out_err;
    logic [1:0]  a_err_count;

    int tests = 0;
    int fails = 0;

    // Model state
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    bit          m_err = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_cnt = 0;
    int          m_addr2 = 56;
    int          m_cnt2 = 0;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err), .err_count(err_count)
    );

    instr_encoder #(.ADDR_W(6), .BASE_ADDR(6'h38), .ERR_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .imm_src(imm_src), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_instr(a_out_instr), .out_addr(a_out_addr),
        .out_err(a_out_err), .err_count(a_err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: range rules in signed arithmetic, fields placed by shifting.
    function automatic void ref_enc(input logic [2:0] src, input logic [6:0] op,
                                    input logic [4:0] d, input logic [4:0] s1,
                                    input logic [4:0] s2, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] im,
                                    output logic [31:0] ins, output bit bad);
        longint si;
        bit     ok;
        si  = longint'($signed(im));
        ok  = 1'b0;
        ins = 32'h0000_0013;
        case (src)
            3'd0: begin
                ok  = (si >= -2048) && (si <= 2047);
                ins = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                    | (32'(d) << 7) | 32'(op);
            end
            3'd1: begin
                ok  = (si >= -2048) && (si <= 2047);
                ins = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                    | (32'(f3) << 12) | ((im & 32'h1F) << 7) | 32'(op);
            end
            3'd2: begin
                ok  = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
                ins = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                    | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                    | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'(op);
            end
            3'd3: begin
                ok  = (si >= -1048576) && (si <= 1048575) && (si % 2 == 0);
                ins = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                    | (32'(d) << 7) | 32'(op);
            end
            3'd4: begin
                ok  = (im % 4096) == 0;
                ins = im + (32'(d) << 7) + 32'(op);
            end
            3'd7: begin
                ok  = 1'b1;
                ins = (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                    | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) ins = 32'h0000_0013;
        bad = !ok;
    endfunction

    task automatic set_in(input bit v, input logic [2:0] src, input logic [6:0] op,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [2:0] f3, input logic [31:0] im);
        in_valid = v; imm_src = src; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = 7'($urandom); imm = im;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic step();
        bit          exp_ready, acc, cmp, ee;
        logic [31:0] ei;
        #3;
        exp_ready = rst_n && (!m_valid || out_ready);
        chk("in_ready", in_ready, exp_ready);
        chk("a_in_ready", a_in_ready, exp_ready);
        ref_enc(imm_src, opcode, rd, rs1, rs2, funct3, funct7, imm, ei, ee);
        acc = in_valid && exp_ready;
        cmp = m_valid && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_instr = '0; m_err = 0; m_addr = '0; m_cnt = 0;
            m_addr2 = 56; m_cnt2 = 0;
        end else begin
            if (cmp) begin
                m_addr  = m_addr + 4;
                m_addr2 = (m_addr2 + 4) % 64;
            end
            if (acc) begin
                m_valid = 1; m_instr = ei; m_err = ee;
                if (ee) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end else if (cmp) begin
                m_valid = 0;
            end
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_instr", out_instr, m_instr);
        chk("out_err", out_err, m_err);
        chk("out_addr", out_addr, m_addr);
        chk("err_count", err_count, 64'(m_cnt));
        chk("a_out_valid", a_out_valid, m_valid);
        chk("a_out_instr", a_out_instr, m_instr);
        chk("a_out_addr", a_out_addr, 64'(m_addr2));
        chk("a_err_count", a_err_count, 64'(m_cnt2));
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; out_ready = 0;
        step();
        rst_n = 1;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] edges [12];
        edges = '{32'h7FF, 32'h800, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'hFFE, 32'h1000,
                  32'hFFFF_F000, 32'hFFFF_EFFE, 32'hF_FFFE, 32'h10_0000, 32'hFFF0_0000,
                  32'hFFEF_FFFE};
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return edges[$urandom_range(0, 11)];
            3: return $urandom & 32'hFFFF_F000;
            default: return 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
        endcase
    endfunction

    initial begin
        // Reset state
        step();
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_addr", out_addr, 32'h0);
        chk("rst_a_addr", a_out_addr, 6'h38);
        rst_n = 1;

        // I-type
        out_ready = 1;
        set_in(1, 3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        step();
        chk("t1_instr", out_instr, 32'h0050_0093);
        chk("t1_addr", out_addr, 32'd0);
        in_valid = 0;
        step();

        // S then B back-to-back
        do_reset();
        out_ready = 1;
        set_in(1, 3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8);
        step();
        chk("t2_s", out_instr, 32'h0020_A423);
        set_in(1, 3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFC);
        step();
        chk("t2_b", out_instr, 32'hFE00_0EE3);
        chk("t2_b_addr", out_addr, 32'd4);
        chk("t2_b_valid", out_valid, 1'b1);

        // J and U
        set_in(1, 3'b011, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
        step();
        chk("t3_j", out_instr, 32'h0010_00EF);
        set_in(1, 3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        step();
        chk("t3_u", out_instr, 32'h1234_52B7);
        in_valid = 0;
        step();

        // Illegal beats
        do_reset();
        out_ready = 1;
        set_in(1, 3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001);
        step();
        chk("t4_u_err", out_err, 1'b1);
        chk("t4_u_addr", out_addr, 32'd0);
        set_in(1, 3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'h1001);
        step();
        chk("t4_b_instr", out_instr, 32'h13);
        chk("t4_b_addr", out_addr, 32'd4);
        set_in(1, 3'b101, 7'b0010011, 5'd3, 5'd4, 5'd5, 3'd0, 32'd0);
        step();
        chk("t4_5_err", out_err, 1'b1);
        chk("t4_5_addr", out_addr, 32'd8);
        chk("t4_count", err_count, 8'd3);
        in_valid = 0;
        step();

        // Backpressure
        do_reset();
        out_ready = 1;
        set_in(1, 3'b000, 7'b0010011, 5'd7, 5'd8, 5'd0, 3'd4, 32'hFFFF_FFFF);
        step();
        out_ready = 0;
        set_in(1, 3'b111, 7'b0110011, 5'd9, 5'd10, 5'd11, 3'd1, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) step();
        chk("t5_held_addr", out_addr, 32'd0);
        chk("t5_held_instr", out_instr, 32'hFFF4_4393);
        out_ready = 1;
        step();
        chk("t5_next_addr", out_addr, 32'd4);
        in_valid = 0;
        step();

        // Reset mid-stream, then saturation of the 2-bit counter
        do_reset();
        out_ready = 1;
        set_in(1, 3'b110, 7'b0010011, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0);
        step();
        step();
        chk("t6_pre_count", err_count, 8'd2);
        rst_n = 0;
        step();
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_addr", out_addr, 32'd0);
        chk("t6_count", err_count, 8'd0);
        rst_n = 1;
        for (int i = 0; i < 5; i++) step();
        chk("t6_sat", a_err_count, 2'd3);
        in_valid = 0;
        step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_in($urandom_range(0, 3) != 0, 3'($urandom), 7'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), 3'($urandom), rand_imm());
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
